tdm_mux_n: RTL and testbench

Parametrised, registered N-channel multiplexer with manual-select and automatic round-robin scan modes. It generalises the fixed 8:1 bit selector to WIDTH-bit channels and an arbitrary channel count. It adds a per-channel dwell counter, valid and frame-start flags, and an enable. It sits between a bank of parallel sources (sensors, counters, register taps) and a single shared serial or display path.

---
 rtl/tdm_pkg.sv | 9 +
 rtl/tdm_scan_ctr.sv | 37 +++
 rtl/tdm_mux_n.sv | 69 ++++++
 tb/tb_tdm_mux_n.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared encodings and sizing helper for the TDM multiplexer
package tdm_pkg;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
   typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_t;
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/tdm_scan_ctr.sv
// tdm_scan_ctr: round-robin channel pointer with per-channel dwell count
module tdm_scan_ctr
   import tdm_pkg::*;
#(
   parameter int N_CH = 8,
   parameter int DWELL = 4,
   localparam int SELW = clog2_min1(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   output logic [SELW-1:0] cur_ch,
   output logic            dwell_last,
   output logic            frame_first
);
   localparam int DW = clog2_min1(DWELL);
   localparam logic [SELW-1:0] CH_LAST = SELW'(N_CH - 1);
   localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);
   logic [DW-1:0] dwell_cnt;
   assign dwell_last  = dwell_cnt == DW_LAST;
   assign frame_first = (cur_ch == '0) && (dwell_cnt == '0);
   // advance dwell, then channel with explicit wrap at the last channel
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cur_ch    <= '0;
         dwell_cnt <= '0;
      end else if (en) begin
         if (dwell_last) begin
            dwell_cnt <= '0;
            cur_ch    <= (cur_ch == CH_LAST) ? '0 : cur_ch + SELW'(1);
         end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
         end
      end
   end
endmodule

// File: rtl/tdm_mux_n.sv
// tdm_mux_n: registered N-channel mux with manual select and round-robin scan
module tdm_mux_n
   import tdm_pkg::*;
#(
   parameter int N_CH = 8,
   parameter int WIDTH = 8,
   parameter int DWELL = 4,
   localparam int SELW = clog2_min1(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] din,
   input  logic [SELW-1:0]       sel,
   input  logic                  mode,
   input  logic                  en,
   output logic [WIDTH-1:0]      dout,
   output logic [SELW-1:0]       ch,
   output logic                  valid,
   output logic                  frame_start
);
   state_t state, state_nxt;
   logic scan, in_range, frame_first, valid_nxt, fs_nxt;
   logic [SELW-1:0] cur_ch, idx, ch_nxt;
   logic [WIDTH-1:0] picked, dout_nxt;
   // leaving MANUAL keeps the counter cleared, so scan entry always starts at channel 0
   tdm_scan_ctr #(.N_CH(N_CH), .DWELL(DWELL)) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .clr        (!scan),
      .en         (en && scan),
      .cur_ch     (cur_ch),
      .dwell_last (),
      .frame_first(frame_first)
   );
   // mode-driven state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_MANUAL;
      else     state <= state_nxt;
   end
   // next state; the transition edge already produces output in the new state
   always_comb begin
      state_nxt = (state == ST_MANUAL) ? ((mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL)
                                       : ((mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN);
      scan      = state_nxt == ST_SCAN;
      idx       = scan ? cur_ch : sel;
      in_range  = int'(idx) < N_CH;
      picked    = '0;
      for (int k = 0; k < N_CH; k++)
         if (idx == SELW'(k)) picked = din[k*WIDTH +: WIDTH];
      dout_nxt  = en ? (in_range ? picked : '0) : dout;
      ch_nxt    = en ? idx : ch;
      valid_nxt = en && in_range;
      fs_nxt    = en && scan && frame_first;
   end
   // output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dout        <= '0;
         ch          <= '0;
         valid       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         dout        <= dout_nxt;
         ch          <= ch_nxt;
         valid       <= valid_nxt;
         frame_start <= fs_nxt;
      end
   end
endmodule

// File: tb/tb_tdm_mux_n.sv
// tb_tdm_mux_n: directed self-checking bench for tdm_mux_n
module tb_tdm_mux_n;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [63:0] din;
   logic [2:0] sel = '0;
   logic mode = 1'b0, en = 1'b0;
   logic [7:0] dout;
   logic [2:0] ch;
   logic valid, frame_start;
   logic [39:0] din5;
   logic [2:0] sel5 = '0;
   logic mode5 = 1'b0, en5 = 1'b0;
   logic [7:0] dout5;
   logic [2:0] ch5;
   logic valid5, frame_start5;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tdm_mux_n u_dut (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
      .dout(dout), .ch(ch), .valid(valid), .frame_start(frame_start)
   );

   tdm_mux_n #(.N_CH(5), .WIDTH(8), .DWELL(1)) u_dut5 (
      .clk(clk), .rst(rst), .din(din5), .sel(sel5), .mode(mode5), .en(en5),
      .dout(dout5), .ch(ch5), .valid(valid5), .frame_start(frame_start5)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] got [2];
      logic [12:0] exp [2];
      rst = 1'b1; mode = 1'b0; en = 1'b1; sel = 3'd3;
      step();
      got[0] = {dout, ch, valid, frame_start};
      exp[0] = '0;
      rst = 1'b0;
      step();
      got[1] = {dout, ch, valid, frame_start};
      exp[1] = {8'h13, 3'd3, 1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (got[i] !== exp[i]) begin
            fails++;
            $display("FAIL reset[%0d]: got dout=%h ch=%0d valid=%b fs=%b, expected dout=%h ch=%0d valid=%b fs=%b",
                     i, got[i][12:5], got[i][4:2], got[i][1], got[i][0], exp[i][12:5], exp[i][4:2], exp[i][1], exp[i][0]);
         end
      end
   endtask

   task automatic test_scan_sequence();
      logic [12:0] got, exp;
      logic [2:0] e;
      do_reset();
      mode = 1'b1; en = 1'b1;
      for (int i = 0; i < 33; i++) begin
         step();
         e = 3'((i / 4) % 8);
         exp = {8'(8'h10 + e), e, 1'b1, 1'(i % 32 == 0)};
         got = {dout, ch, valid, frame_start};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL scan_seq[%0d]: got dout=%h ch=%0d valid=%b fs=%b, expected dout=%h ch=%0d valid=%b fs=%b",
                     i, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_enable_gap();
      logic [12:0] got [9];
      logic [12:0] exp [9];
      do_reset();
      mode = 1'b1; en = 1'b1;
      repeat (10) step();
      got[0] = {dout, ch, valid, frame_start};
      exp[0] = {8'h12, 3'd2, 1'b1, 1'b0};
      en = 1'b0;
      din[2*8 +: 8] = 8'hAA;
      for (int i = 1; i <= 5; i++) begin
         step();
         got[i] = {dout, ch, valid, frame_start};
         exp[i] = {8'h12, 3'd2, 1'b0, 1'b0};
      end
      din[2*8 +: 8] = 8'h12;
      en = 1'b1;
      for (int i = 6; i < 9; i++) begin
         step();
         got[i] = {dout, ch, valid, frame_start};
      end
      exp[6] = {8'h12, 3'd2, 1'b1, 1'b0};
      exp[7] = {8'h12, 3'd2, 1'b1, 1'b0};
      exp[8] = {8'h13, 3'd3, 1'b1, 1'b0};
      for (int i = 0; i < 9; i++) begin
         tests++;
         if (got[i] !== exp[i]) begin
            fails++;
            $display("FAIL enable_gap[%0d]: got dout=%h ch=%0d valid=%b fs=%b, expected dout=%h ch=%0d valid=%b fs=%b",
                     i, got[i][12:5], got[i][4:2], got[i][1], got[i][0], exp[i][12:5], exp[i][4:2], exp[i][1], exp[i][0]);
         end
      end
   endtask

   task automatic test_five_channels();
      logic [12:0] got [8];
      logic [12:0] exp [8];
      do_reset();
      mode5 = 1'b0; en5 = 1'b1; sel5 = 3'd6;
      step();
      got[0] = {dout5, ch5, valid5, frame_start5};
      exp[0] = {8'h00, 3'd6, 1'b0, 1'b0};
      sel5 = 3'd4;
      step();
      got[1] = {dout5, ch5, valid5, frame_start5};
      exp[1] = {8'h14, 3'd4, 1'b1, 1'b0};
      mode5 = 1'b1;
      for (int i = 2; i < 8; i++) begin
         step();
         got[i] = {dout5, ch5, valid5, frame_start5};
      end
      exp[2] = {8'h10, 3'd0, 1'b1, 1'b1};
      exp[3] = {8'h11, 3'd1, 1'b1, 1'b0};
      exp[4] = {8'h12, 3'd2, 1'b1, 1'b0};
      exp[5] = {8'h13, 3'd3, 1'b1, 1'b0};
      exp[6] = {8'h14, 3'd4, 1'b1, 1'b0};
      exp[7] = {8'h10, 3'd0, 1'b1, 1'b1};
      en5 = 1'b0; mode5 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (got[i] !== exp[i]) begin
            fails++;
            $display("FAIL five_ch[%0d]: got dout=%h ch=%0d valid=%b fs=%b, expected dout=%h ch=%0d valid=%b fs=%b",
                     i, got[i][12:5], got[i][4:2], got[i][1], got[i][0], exp[i][12:5], exp[i][4:2], exp[i][1], exp[i][0]);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [12:0] got [8];
      logic [12:0] exp [8];
      do_reset();
      mode = 1'b1; en = 1'b1; sel = 3'd2;
      repeat (21) step();
      got[0] = {dout, ch, valid, frame_start};
      exp[0] = {8'h15, 3'd5, 1'b1, 1'b0};
      mode = 1'b0;
      step();
      got[1] = {dout, ch, valid, frame_start};
      exp[1] = {8'h12, 3'd2, 1'b1, 1'b0};
      mode = 1'b1;
      step();
      got[2] = {dout, ch, valid, frame_start};
      exp[2] = {8'h10, 3'd0, 1'b1, 1'b1};
      step();
      got[3] = {dout, ch, valid, frame_start};
      exp[3] = {8'h10, 3'd0, 1'b1, 1'b0};
      repeat (4) step();
      got[4] = {dout, ch, valid, frame_start};
      exp[4] = {8'h11, 3'd1, 1'b1, 1'b0};
      en = 1'b0; mode = 1'b0;
      step();
      got[5] = {dout, ch, valid, frame_start};
      exp[5] = {8'h11, 3'd1, 1'b0, 1'b0};
      mode = 1'b1;
      step();
      got[6] = {dout, ch, valid, frame_start};
      exp[6] = {8'h11, 3'd1, 1'b0, 1'b0};
      en = 1'b1;
      step();
      got[7] = {dout, ch, valid, frame_start};
      exp[7] = {8'h10, 3'd0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (got[i] !== exp[i]) begin
            fails++;
            $display("FAIL mode_switch[%0d]: got dout=%h ch=%0d valid=%b fs=%b, expected dout=%h ch=%0d valid=%b fs=%b",
                     i, got[i][12:5], got[i][4:2], got[i][1], got[i][0], exp[i][12:5], exp[i][4:2], exp[i][1], exp[i][0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [12:0] got [3];
      logic [12:0] exp [3];
      do_reset();
      mode = 1'b1; en = 1'b1;
      repeat (25) step();
      got[0] = {dout, ch, valid, frame_start};
      exp[0] = {8'h16, 3'd6, 1'b1, 1'b0};
      rst = 1'b1;
      step();
      got[1] = {dout, ch, valid, frame_start};
      exp[1] = '0;
      rst = 1'b0;
      step();
      got[2] = {dout, ch, valid, frame_start};
      exp[2] = {8'h10, 3'd0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (got[i] !== exp[i]) begin
            fails++;
            $display("FAIL reset_mid[%0d]: got dout=%h ch=%0d valid=%b fs=%b, expected dout=%h ch=%0d valid=%b fs=%b",
                     i, got[i][12:5], got[i][4:2], got[i][1], got[i][0], exp[i][12:5], exp[i][4:2], exp[i][1], exp[i][0]);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'(8'h10 + k);
      for (int k = 0; k < 5; k++) din5[k*8 +: 8] = 8'(8'h10 + k);
      test_reset();
      test_scan_sequence();
      test_enable_gap();
      test_five_channels();
      test_mode_switch();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "timeout");
   end
endmodule
